// File: rtl/jiancheng_disp_if.sv
// Bundles the jiancheng_disp data, handshake and display signals.
// The master modport is the upstream/board side; the slave modport is the display stage.
interface jiancheng_disp_if;
  logic [6:0]  c_in;
  logic        load;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;

  modport master (
    output c_in, load,
    input  busy, done, bcd, seg, an
  );

  modport slave (
    input  c_in, load,
    output busy, done, bcd, seg, an
  );
endinterface

// File: rtl/jiancheng_disp.sv
// Captures the 7-bit jiancheng result, converts it to BCD with a serial double-dabble engine,
// and scans the three digits onto a common-anode 7-segment display with leading-zero blanking.
module jiancheng_disp #(
  parameter int SCAN_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  jiancheng_disp_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  bin_q, bin_d;
  logic [11:0] scratch_q, scratch_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] bcd_q, bcd_d;
  logic        done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;

  logic [11:0] adj;
  logic [3:0]  digit;
  logic        blank;
  logic [6:0]  seg;
  logic [2:0]  an;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      adj[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ? scratch_q[4*k +: 4] + 4'd3
                                                     : scratch_q[4*k +: 4];
    end
  end

  // bcd only moves in DONE, so the display never sees a half-converted value.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          bin_d     = bus.c_in;
          scratch_d = 12'h000;
          iter_d    = 3'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[10:0], bin_q[6]};
        bin_d     = {bin_q[5:0], 1'b0};
        iter_d    = iter_q + 3'd1;
        if (iter_q == 3'd6) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_comb begin
    digit = bcd_q[3:0];
    an    = 3'b110;
    blank = 1'b0;
    case (idx_q)
      2'd1: begin
        digit = bcd_q[7:4];
        an    = 3'b101;
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        digit = bcd_q[11:8];
        an    = 3'b011;
        blank = (bcd_q[11:8] == 4'd0);
      end
      default: ;
    endcase
    seg = blank ? 7'b1111111 : seg_of(digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= 7'd0;
      scratch_q <= 12'h000;
      iter_q    <= 3'd0;
      bcd_q     <= 12'h000;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.seg  = seg;
  assign bus.an   = an;

endmodule

// File: tb/tb_jiancheng_disp.sv
// Self-checking bench for jiancheng_disp: table-driven conversions with a bcd scoreboard,
// plus hand-written sequences for ignored loads, back-to-back loads and reset mid-conversion.
module tb_jiancheng_disp;

  localparam int SD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  jiancheng_disp_if bus();

  jiancheng_disp #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] sb[$];

  typedef struct {
    logic [6:0]  c;
    logic [11:0] bcd;
    logic [6:0]  seg_o;
    logic [6:0]  seg_t;
    logic [6:0]  seg_h;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting, expected event never seen", name);
  endtask

  // Drive inputs at a falling edge, then advance to the next falling edge.
  task automatic applyStimulus(input logic [6:0] c, input logic ld);
    bus.c_in = c;
    bus.load = ld;
    @(negedge clk);
  endtask

  // Every done pulse must match the oldest outstanding expected value.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        timeoutFail("unexpected_done");
      end else begin
        checkOutput("scoreboard_bcd", bus.bcd, sb.pop_front());
      end
    end
  end

  task automatic runConversion(input logic [6:0] c, input logic [11:0] exp);
    int n;
    n = 0;
    sb.push_back(exp);
    applyStimulus(c, 1'b1);
    bus.load = 1'b0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      applyStimulus(c, 1'b0);
    end
    checkOutput("busy_cycles", 12'(n), 12'd8);
    checkOutput("done_pulse", 12'(bus.done), 12'd1);
    checkOutput("bcd_value", bus.bcd, exp);
    applyStimulus(c, 1'b0);
    checkOutput("done_one_cycle", 12'(bus.done), 12'd0);
  endtask

  task automatic checkDigits(input vec_t v);
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    int n;
    for (int d = 0; d < 3; d++) begin
      exp_an  = (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b011;
      exp_seg = (d == 0) ? v.seg_o : (d == 1) ? v.seg_t : v.seg_h;
      n = 0;
      while (bus.an !== exp_an && n < 3 * SD + 2) begin
        n++;
        @(negedge clk);
      end
      if (bus.an !== exp_an) begin
        timeoutFail($sformatf("an_digit%0d_c%0d", d, v.c));
      end else begin
        checkOutput($sformatf("seg_digit%0d_c%0d", d, v.c), 12'(bus.seg), 12'(exp_seg));
      end
    end
  endtask

  task automatic measureDwell();
    logic [2:0] a;
    int n;
    a = bus.an;
    n = 0;
    while (bus.an === a && n < 20) begin
      n++;
      @(negedge clk);
    end
    a = bus.an;
    n = 0;
    while (bus.an === a && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("digit_dwell", 12'(n), 12'(SD));
  endtask

  initial begin
    int dn;
    int first_done;
    int second_done;
    logic [6:0] cv;

    vecs[0] = '{7'd127, 12'h127, 7'b1111000, 7'b0100100, 7'b1111001};
    vecs[1] = '{7'd14,  12'h014, 7'b0011001, 7'b1111001, 7'b1111111};
    vecs[2] = '{7'd100, 12'h100, 7'b1000000, 7'b1000000, 7'b1111001};
    vecs[3] = '{7'd0,   12'h000, 7'b1000000, 7'b1111111, 7'b1111111};
    vecs[4] = '{7'd63,  12'h063, 7'b0110000, 7'b0000010, 7'b1111111};
    vecs[5] = '{7'd99,  12'h099, 7'b0010000, 7'b0010000, 7'b1111111};
    vecs[6] = '{7'd5,   12'h005, 7'b0010010, 7'b1111111, 7'b1111111};
    vecs[7] = '{7'd58,  12'h058, 7'b0000000, 7'b0010010, 7'b1111111};

    bus.c_in = 7'd0;
    bus.load = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_bcd",  bus.bcd, 12'h000);
    checkOutput("reset_an",   12'(bus.an), 12'(3'b110));
    checkOutput("reset_seg",  12'(bus.seg), 12'(7'b1000000));
    checkOutput("reset_busy", 12'(bus.busy), 12'd0);
    checkOutput("reset_done", 12'(bus.done), 12'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_bcd",  bus.bcd, 12'h000);
    checkOutput("post_reset_busy", 12'(bus.busy), 12'd0);

    for (int i = 0; i < 8; i++) begin
      runConversion(vecs[i].c, vecs[i].bcd);
      checkDigits(vecs[i]);
      if (i == 0) measureDwell();
    end

    // Loads during SHIFT (k+3) and DONE (k+8) must be dropped.
    sb.push_back(12'h005);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      cv = (i == 0) ? 7'd5 : 7'd99;
      applyStimulus(cv, (i == 0) || (i == 3) || (i == 8));
      if (bus.done === 1'b1) dn++;
    end
    checkOutput("ignored_load_done_count", 12'(dn), 12'd1);
    checkOutput("ignored_load_bcd", bus.bcd, 12'h005);

    // Load held high: captures every 9 cycles.
    sb.push_back(12'h042);
    sb.push_back(12'h042);
    first_done  = -1;
    second_done = -1;
    for (int i = 0; i < 23; i++) begin
      applyStimulus(7'd42, i < 18);
      if (bus.done === 1'b1) begin
        if (first_done < 0) first_done = i;
        else second_done = i;
      end
    end
    checkOutput("held_load_first_done", 12'(first_done), 12'd8);
    checkOutput("held_load_second_done", 12'(second_done), 12'd17);

    // Reset lands between edges k+3 and k+4 of a conversion of 127.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(7'd127, i == 0);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort_bcd",  bus.bcd, 12'h000);
    checkOutput("abort_busy", 12'(bus.busy), 12'd0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(7'd127, 1'b0);
      if (bus.done === 1'b1) dn++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(7'd127, 1'b0);
      if (bus.done === 1'b1) dn++;
    end
    checkOutput("abort_no_done", 12'(dn), 12'd0);
    checkOutput("abort_bcd_held", bus.bcd, 12'h000);
    runConversion(7'd63, 12'h063);
    checkDigits(vecs[4]);

    if (sb.size() != 0) timeoutFail("scoreboard_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
